// File: rtl/clksw_ctrl_if.sv
// Request/status interface between a switch requester and the clock-select
// sequencer. The sequencer owns select, status and pulse outputs.
interface clksw_ctrl_if;
  logic req_valid;
  logic req_sel;
  logic req_ready;
  logic select;
  logic cur_sel;
  logic busy;
  logic done;
  logic err;

  modport master (
    output req_valid, req_sel,
    input  req_ready, select, cur_sel, busy, done, err
  );

  modport slave (
    input  req_valid, req_sel,
    output req_ready, select, cur_sel, busy, done, err
  );
endinterface

// File: rtl/clksw_ctrl.sv
// Clock-select sequencer for a glitch-free two-clock mux. Accepts switch
// requests, drives select, waits a settle window, then confirms the new
// source is alive by counting synchronized toggles of its divide-by-2
// signal. A dead target causes select to revert and an err pulse.
module clksw_ctrl #(
  parameter int unsigned SETTLE_CYCLES  = 8,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned MIN_EDGES      = 2,
  parameter int unsigned CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tog_a,
  input  logic        tog_b,
  clksw_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    CHECK,
    REVERT
  } state_e;

  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_CNT      = CNT_W'(MIN_EDGES);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
  logic             target_q, target_d;
  logic             select_q, select_d;
  logic             cur_sel_q, cur_sel_d;
  logic             done_q, done_d;
  logic             err_q, err_d;

  logic [1:0]       a_sync_q, b_sync_q;
  logic             a_hist_q, b_hist_q;
  logic             edge_a, edge_b, edge_sel;
  logic [CNT_W-1:0] edge_sum;

  // Two-flop synchronizers plus history flop; run in every state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sync_q <= '0;
      b_sync_q <= '0;
      a_hist_q <= 1'b0;
      b_hist_q <= 1'b0;
    end else begin
      a_sync_q <= {a_sync_q[0], tog_a};
      b_sync_q <= {b_sync_q[0], tog_b};
      a_hist_q <= a_sync_q[1];
      b_hist_q <= b_sync_q[1];
    end
  end

  assign edge_a   = a_sync_q[1] ^ a_hist_q;
  assign edge_b   = b_sync_q[1] ^ b_hist_q;
  assign edge_sel = target_q ? edge_b : edge_a;
  assign edge_sum = edge_cnt_q + {{(CNT_W-1){1'b0}}, edge_sel};

  // Sequencer state and output registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      edge_cnt_q <= '0;
      target_q   <= 1'b0;
      select_q   <= 1'b0;
      cur_sel_q  <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      edge_cnt_q <= edge_cnt_d;
      target_q   <= target_d;
      select_q   <= select_d;
      cur_sel_q  <= cur_sel_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // Next-state logic: accept, settle, confirm target clock, or revert.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    edge_cnt_d = edge_cnt_q;
    target_d   = target_q;
    select_d   = select_q;
    cur_sel_d  = cur_sel_q;
    done_d     = 1'b0;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          if (bus.req_sel == cur_sel_q) begin
            done_d = 1'b1;
          end else begin
            target_d = bus.req_sel;
            select_d = bus.req_sel;
            cnt_d    = '0;
            state_d  = SETTLE;
          end
        end
      end

      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d      = '0;
          edge_cnt_d = '0;
          state_d    = CHECK;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Success is tested before timeout so a final-cycle edge still wins.
      CHECK: begin
        if (edge_sum >= MIN_CNT) begin
          edge_cnt_d = MIN_CNT;
          cur_sel_d  = target_q;
          done_d     = 1'b1;
          cnt_d      = '0;
          state_d    = IDLE;
        end else if (cnt_q == TIMEOUT_LAST) begin
          select_d = cur_sel_q;
          cnt_d    = '0;
          state_d  = REVERT;
        end else begin
          edge_cnt_d = edge_sum;
          cnt_d      = cnt_q + 1'b1;
        end
      end

      REVERT: begin
        if (cnt_q == SETTLE_LAST) begin
          err_d   = 1'b1;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.select    = select_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;

endmodule
